// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main control FSM: state encoding,
// datapath mux-select encodings and the packed control-word layout.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_MULEX   = 4'd10,
        S_MULWB   = 4'd11,
        S_FPUEX   = 4'd12,
        S_FPUWB   = 4'd13,
        S_UNKNOWN = 4'd15
    } state_t;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_A  = 2'b00;
    localparam logic [1:0] SRCA_PC = 2'b01;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // One complete set of control outputs for a given state
    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       reg_src_64b;
        logic       src_64b;
        logic       fpu_write;
        logic       fault;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational State -> control-word decode. Outputs depend only on the
// state (Moore), except Src_64b in MULWB which follows the latched Funct[3].
import mc_ctrl_pkg::*;

module mc_ctrl_rom (
    input  state_t     state,
    input  logic       funct3,
    output ctrl_word_t ctrl
);

    // Decode the current state into its strobes; anything unlisted stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
                ctrl.next_pc    = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_MEMADR: begin
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adr_src = 1'b1;
                ctrl.mem_w   = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_op = 1'b1;
            end
            S_EXECI: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            S_ALUWB: begin
                ctrl.reg_w = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURESULT;
                ctrl.branch     = 1'b1;
            end
            S_MULEX: begin
                ctrl.reg_src_64b = 1'b1;
                ctrl.alu_op      = 1'b1;
            end
            S_MULWB: begin
                ctrl.reg_src_64b = 1'b1;
                ctrl.reg_w       = 1'b1;
                ctrl.src_64b     = funct3;
            end
            S_FPUEX: begin
                ctrl = '0;
            end
            S_FPUWB: begin
                ctrl.fpu_write = 1'b1;
            end
            S_UNKNOWN: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_mainfsm.sv
// Multicycle main control FSM. Holds the state register, next-state logic
// and the FPU latency counter; output decoding is delegated to mc_ctrl_rom.
import mc_ctrl_pkg::*;

module mc_mainfsm #(
    parameter int unsigned FPU_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MulOp,
    input  logic       FpuOp,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       RegSrc64b,
    output logic       Src_64b,
    output logic       FPUWrite,
    output logic       Fault,
    output logic [3:0] State
);

    // Counter preload so that FPUEX occupies exactly FPU_LAT cycles
    localparam logic [3:0] FPU_WAIT_LOAD = 4'(FPU_LAT - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] wait_cnt_reg;
    logic [3:0] wait_cnt_next;
    ctrl_word_t ctrl;

    // Funct bits that never steer this FSM; kept here to document that
    logic unused_funct;
    assign unused_funct = &{1'b0, Funct[4], Funct[2:1]};

    // State and FPU wait counter registers, asynchronously cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state selection and FPU wait counter sequencing
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (Op == 2'b00 && MulOp) begin
                    state_next = S_MULEX;
                end else if (Op == 2'b00 && Funct[5]) begin
                    state_next = S_EXECI;
                end else if (Op == 2'b00) begin
                    state_next = S_EXECR;
                end else if (Op == 2'b01) begin
                    state_next = S_MEMADR;
                end else if (Op == 2'b10) begin
                    state_next = S_BRANCH;
                end else if (FpuOp) begin
                    state_next    = S_FPUEX;
                    wait_cnt_next = FPU_WAIT_LOAD;
                end else begin
                    state_next = S_UNKNOWN;
                end
            end
            S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = S_FETCH;
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_MULEX:  state_next = S_MULWB;
            S_MULWB:  state_next = S_FETCH;
            S_FPUEX: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = S_FPUWB;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            S_FPUWB:   state_next = S_FETCH;
            S_UNKNOWN: state_next = S_UNKNOWN;
            default:   state_next = S_UNKNOWN;
        endcase
    end

    mc_ctrl_rom u_rom (
        .state  (state_reg),
        .funct3 (Funct[3]),
        .ctrl   (ctrl)
    );

    // Fan the control word out to the individual datapath strobes
    always_comb begin
        IRWrite   = ctrl.ir_write;
        AdrSrc    = ctrl.adr_src;
        ALUSrcA   = ctrl.alu_src_a;
        ALUSrcB   = ctrl.alu_src_b;
        ResultSrc = ctrl.result_src;
        NextPC    = ctrl.next_pc;
        RegW      = ctrl.reg_w;
        MemW      = ctrl.mem_w;
        Branch    = ctrl.branch;
        ALUOp     = ctrl.alu_op;
        RegSrc64b = ctrl.reg_src_64b;
        Src_64b   = ctrl.src_64b;
        FPUWrite  = ctrl.fpu_write;
        Fault     = ctrl.fault;
        State     = state_reg;
    end

endmodule

// File: tb/tb_mc_mainfsm.sv
// Directed bench for mc_mainfsm: expected per-cycle output words are queued
// as each instruction is driven and compared cycle by cycle.
module tb_mc_mainfsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MulOp;
    logic       FpuOp;

    logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
    logic       RegSrc64b, Src_64b, FPUWrite, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;

    logic       IRWrite1, AdrSrc1, NextPC1, RegW1, MemW1, Branch1, ALUOp1;
    logic       RegSrc64b1, Src_64b1, FPUWrite1, Fault1;
    logic [1:0] ALUSrcA1, ALUSrcB1, ResultSrc1;
    logic [3:0] State1;

    int checks = 0;
    int passes = 0;

    logic [20:0] exp_q[$];

    mc_mainfsm #(.FPU_LAT(3)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .FpuOp(FpuOp),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .ALUOp(ALUOp), .RegSrc64b(RegSrc64b), .Src_64b(Src_64b), .FPUWrite(FPUWrite),
        .Fault(Fault), .State(State)
    );

    mc_mainfsm #(.FPU_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .FpuOp(FpuOp),
        .IRWrite(IRWrite1), .AdrSrc(AdrSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
        .ResultSrc(ResultSrc1), .NextPC(NextPC1), .RegW(RegW1), .MemW(MemW1), .Branch(Branch1),
        .ALUOp(ALUOp1), .RegSrc64b(RegSrc64b1), .Src_64b(Src_64b1), .FPUWrite(FPUWrite1),
        .Fault(Fault1), .State(State1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word for a state, straight from the per-state table
    function automatic logic [20:0] exp_word(input logic [3:0] st, input logic f3);
        logic       irw, adr, npc, rw, mw, br, aop, r64, s64, fw, flt;
        logic [1:0] sa, sb, rs;
        {irw, adr, npc, rw, mw, br, aop, r64, s64, fw, flt} = '0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00;
        case (st)
            4'd0:  begin irw = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; npc = 1; end
            4'd1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            4'd2:  sb = 2'b01;
            4'd3:  adr = 1;
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  aop = 1;
            4'd7:  begin sb = 2'b01; aop = 1; end
            4'd8:  rw = 1;
            4'd9:  begin sb = 2'b01; rs = 2'b10; br = 1; end
            4'd10: begin r64 = 1; aop = 1; end
            4'd11: begin r64 = 1; rw = 1; s64 = f3; end
            4'd13: fw = 1;
            4'd15: flt = 1;
            default: ;
        endcase
        return {st, irw, adr, sa, sb, rs, npc, rw, mw, br, aop, r64, s64, fw, flt};
    endfunction

    function automatic logic [20:0] dut_word();
        return {State, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW,
                Branch, ALUOp, RegSrc64b, Src_64b, FPUWrite, Fault};
    endfunction

    task automatic push(input logic [3:0] st);
        exp_q.push_back(exp_word(st, Funct[3]));
    endtask

    // Pop one expected word and compare with the DUT outputs right now
    task automatic check_one(input string tag);
        logic [20:0] e;
        logic [20:0] a;
        checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: scoreboard empty, observed %h", tag, dut_word());
        end else begin
            e = exp_q.pop_front();
            a = dut_word();
            assert (a === e) passes++;
            else $error("FAIL %s: observed %h expected %h", tag, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every queued cycle, advancing one clock after each
    task automatic drain(input string tag);
        int n;
        n = exp_q.size();
        while (exp_q.size() > 0) begin
            check_one(tag);
            step();
        end
        $display("txn %-8s cycles=%0d", tag, n);
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic mul, input logic fpu);
        Op = op; Funct = fn; MulOp = mul; FpuOp = fpu;
    endtask

    initial begin
        logic [3:0] lat1_states [6];
        reset = 1'b1;
        drive(2'b00, 6'b000000, 1'b0, 1'b0);

        // Reset held three cycles: FETCH word throughout
        repeat (3) step();
        push(4'd0);
        check_one("reset");
        reset = 1'b0;

        // LDR: 0,1,2,3,4
        drive(2'b01, 6'b011001, 1'b0, 1'b0);
        push(0); push(1); push(2); push(3); push(4);
        drain("LDR");

        // STR: 0,1,2,5
        drive(2'b01, 6'b011000, 1'b0, 1'b0);
        push(0); push(1); push(2); push(5);
        drain("STR");

        // DP register: 0,1,6,8
        drive(2'b00, 6'b000100, 1'b0, 1'b0);
        push(0); push(1); push(6); push(8);
        drain("DPREG");

        // DP immediate: 0,1,7,8
        drive(2'b00, 6'b100100, 1'b0, 1'b0);
        push(0); push(1); push(7); push(8);
        drain("DPIMM");

        // Branch: 0,1,9
        drive(2'b10, 6'b000000, 1'b0, 1'b0);
        push(0); push(1); push(9);
        drain("B");

        // UMULL: 64-bit writeback
        drive(2'b00, 6'b001000, 1'b1, 1'b0);
        push(0); push(1); push(10); push(11);
        drain("UMULL");

        // MUL with Funct[5] set: MulOp wins over immediate DP, Src_64b=0
        drive(2'b00, 6'b100000, 1'b1, 1'b0);
        push(0); push(1); push(10); push(11);
        drain("MULPRI");

        // FP op with FPU_LAT=3
        drive(2'b11, 6'b000000, 1'b0, 1'b1);
        push(0); push(1); push(12); push(12); push(12); push(13);
        drain("FP");

        // FP op interrupted by reset in the 2nd FPUEX cycle
        push(0); push(1); push(12);
        drain("FPPRE");
        push(12);
        check_one("fpuex2");
        reset = 1'b1;
        #1;
        push(0);
        check_one("rst_async");
        step();
        push(0);
        check_one("rst_hold");
        reset = 1'b0;
        push(0); push(1); push(12); push(12); push(12); push(13);
        drain("FPAFTER");

        // Undefined: Op=11, FpuOp=0 -> absorbing UNKNOWN
        drive(2'b11, 6'b000000, 1'b0, 1'b0);
        push(0); push(1);
        drain("UNDEF");
        for (int i = 0; i < 20; i++) begin
            push(15);
            check_one("unknown");
            Op = Op + 2'd1;
            step();
        end
        reset = 1'b1;
        #1;
        push(0);
        check_one("rst_fault");
        step();
        reset = 1'b0;
        $display("txn %-8s cycles=20", "UNKHOLD");

        // FPU_LAT=1 instance alongside FPU_LAT=3, both freshly reset
        drive(2'b11, 6'b000000, 1'b0, 1'b1);
        lat1_states[0] = 4'd0;  lat1_states[1] = 4'd1;  lat1_states[2] = 4'd12;
        lat1_states[3] = 4'd13; lat1_states[4] = 4'd0;  lat1_states[5] = 4'd1;
        push(0); push(1); push(12); push(12); push(12); push(13);
        for (int i = 0; i < 6; i++) begin
            check_one("fp_lat3");
            checks++;
            assert (State1 === lat1_states[i]) passes++;
            else $error("FAIL fp_lat1 cycle %0d: observed %0d expected %0d",
                        i, State1, lat1_states[i]);
            step();
        end
        $display("txn %-8s cycles=6", "FPLAT1");
        push(0);
        check_one("final_fetch");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mc_mainfsm.md
Name: mc_mainfsm

Overview:
Multicycle main control FSM that drives the datapath's strobes and mux selects, one instruction at a time. It covers the base ARM set (data-processing, LDR/STR, B) plus the MUL/UMULL 64-bit path and the FP coprocessor path. It sits upstream of the datapath, fed by decoded Instr fields. Condition checking and PC-write gating (NextPC/Branch against the flags) live in the separate cond-logic block downstream.

Parameters:
FPU_LAT, 2, cycles from FP operand capture to a valid FPU result register; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
MulOp  in  1  high when Op==00 and Instr[7:4]==4'b1001
FpuOp  in  1  high when Op==11 and the coprocessor field selects the FPU
IRWrite  out  1  instruction register load
AdrSrc  out  1  0=PC, 1=Result
ALUSrcA  out  2  00=A, 01=PC
ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=const 4
ResultSrc  out  2  00=ALUOut32, 01=Data, 10=ALUResult32
NextPC  out  1  PC update request
RegW  out  1  integer regfile write request
MemW  out  1  memory write request
Branch  out  1  branch request
ALUOp  out  1  1=ALU decoder uses Funct; 0=add
RegSrc64b  out  1  multiply register-address routing
Src_64b  out  1  64-bit (RdHi:RdLo) writeback
FPUWrite  out  1  FP regfile write
Fault  out  1  undefined instruction trap
State  out  4  current state, for debug

Behaviour:
- Interface: one clock domain, clk. reset is asynchronous and active-high. While reset is high, State = FETCH.
- Moore machine: every output is a pure decode of State. While reset is asserted and on the first cycle after it, outputs therefore equal the FETCH word.
- Any control output not listed for a state is 0.
- State encoding, 4 bits:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
  - MULEX=10, MULWB=11, FPUEX=12, FPUWB=13, UNKNOWN=15
- Outputs per state:
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - MULEX: RegSrc64b=1, ALUOp=1.
  - MULWB: RegSrc64b=1, RegW=1, Src_64b=Funct[3].
  - FPUEX: no strobes.
  - FPUWB: FPUWrite=1.
  - UNKNOWN: Fault=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE, in priority order:
    - Op=00 & MulOp → MULEX
    - Op=00 & Funct[5] → EXECI
    - Op=00 → EXECR
    - Op=01 → MEMADR
    - Op=10 → BRANCH
    - Op=11 & FpuOp → FPUEX
    - otherwise → UNKNOWN
  - MEMADR: Funct[0]=1 → MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECR and EXECI → ALUWB → FETCH. BRANCH→FETCH.
  - MULEX→MULWB→FETCH.
  - FPUEX: on entry, the 4-bit wait counter loads FPU_LAT-1. Decrement each cycle. Leave to FPUWB in the cycle the counter reads 0, so FPUEX lasts exactly FPU_LAT cycles. FPUWB→FETCH.
  - UNKNOWN: absorbing; only reset exits it.
- Cycle counts, including FETCH:
  - LDR 5; STR 4; DP 4; B 3; MUL 4; FP 3+FPU_LAT.
- Funct, Op, MulOp and FpuOp are sampled only in DECODE and MEMADR (and MULWB for Src_64b); they are stable from the IR.
- MulOp and FpuOp high together is impossible by encoding. Priority resolves it anyway: MulOp requires Op=00, FpuOp requires Op=11.
- Reset mid-instruction (any state, including FPUEX with counter ≠ 0): asynchronous return to FETCH and counter cleared. No write strobe is asserted during or after reset until the FSM reaches the relevant state again.
- FPU_LAT=1: FPUEX lasts one cycle.
- Unused encoding 14: next state UNKNOWN.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state enum constants;
  - the ALUSrcA/ALUSrcB/ResultSrc encodings;
  - a packed control-word layout.
- One natural sub-module: mc_ctrl_rom, combinational State→control-word decode. The FSM register, next-state logic and FPU wait counter stay in mc_mainfsm.

Test Plan:
- Reset held 3 cycles, then released → State=0, IRWrite=1, NextPC=1, ALUSrcB=10, all other strobes 0. The next cycle State=1.
- LDR: Op=01, Funct=011001 → states 0,1,2,3,4,0. RegW=1 only in the state-4 cycle, with ResultSrc=01.
- STR: Op=01, Funct=011000 → states 0,1,2,5,0. MemW=1 in exactly one cycle, with AdrSrc=1.
- UMULL: Op=00, MulOp=1, Funct=001000 → states 0,1,10,11,0. RegSrc64b=1 in both 10 and 11; in 11, Src_64b=1 and RegW=1.
- FP op with FPU_LAT=3: Op=11, FpuOp=1 → FPUEX for exactly 3 cycles, then FPUWB with FPUWrite=1 for one cycle, then FETCH. Asserting reset during the 2nd FPUEX cycle → immediate State=0, and FPUWrite never asserts.
- Op=11, FpuOp=0 → UNKNOWN with Fault=1, held for 20 cycles with Op toggling. reset → FETCH, Fault=0.
